shot_detector: RTL and testbench

- Light-gun shot evaluator; sits directly upstream of the pattern generator, between the raw gun inputs and the VGA pattern stage.
- On a trigger pull it sequences one all-black frame, then one target-only frame, and samples the photodiode during each.
- Drives blank/target-display requests to the pattern generator and emits hit/miss pulses plus a hit counter.
- All logic runs on the VGA pixel clock.

---
 rtl/shot_detector.sv | 178 +++++++++++++++++
 tb/tb_shot_detector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_detector.sv
// Light-gun shot evaluator: on a trigger pull, sequences a black frame then a target frame and judges hit/miss.
// Optional trigger debounce is built in when TRIGGER_DEBOUNCE_EN is defined.
module shot_detector #(
  parameter int MIN_DETECT      = 16,
  parameter int CNT_W           = 12,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       detect,
  input  logic       frame_start,
  input  logic       valid,
  output logic       blank_screen,
  output logic       show_target,
  output logic       hit,
  output logic       miss,
  output logic       busy,
  output logic [7:0] hit_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM      = 3'd1;
  localparam logic [2:0] S_BLACK    = 3'd2;
  localparam logic [2:0] S_WHITE    = 3'd3;
  localparam logic [2:0] S_EVAL     = 3'd4;
  localparam logic [2:0] S_COOLDOWN = 3'd5;

  localparam int              FC_W    = $clog2(COOLDOWN_FRAMES + 2);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_DET = CNT_W'(MIN_DETECT);

  logic [1:0]       trig_sync_reg;
  logic [1:0]       det_sync_reg;
  logic             trig_s;
  logic             detect_s;
  logic             trig_level;
  logic             trig_prev_reg;
  logic             trig_edge_reg;
  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic             black_light_reg;
  logic [CNT_W-1:0] det_cnt_reg;
  logic [FC_W-1:0]  frame_cnt_reg;
  logic [FC_W-1:0]  frame_cnt_inc;
  logic             blank_reg;
  logic             show_reg;
  logic             hit_reg;
  logic             miss_reg;
  logic             busy_reg;
  logic [7:0]       hit_count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      trig_sync_reg <= '0;
      det_sync_reg  <= '0;
    end else begin
      trig_sync_reg <= {trig_sync_reg[0], trigger};
      det_sync_reg  <= {det_sync_reg[0], detect};
    end
  end

  assign trig_s   = trig_sync_reg[1];
  assign detect_s = det_sync_reg[1];

`ifdef TRIGGER_DEBOUNCE_EN
  localparam int            DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_reg;
  logic            trig_db_reg;

  // Any low sample restarts the qualification window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      db_cnt_reg  <= '0;
      trig_db_reg <= 1'b0;
    end else if (!trig_s) begin
      db_cnt_reg  <= '0;
      trig_db_reg <= 1'b0;
    end else if (db_cnt_reg == DB_LAST) begin
      trig_db_reg <= 1'b1;
    end else begin
      db_cnt_reg <= db_cnt_reg + 1'b1;
    end
  end

  assign trig_level = trig_db_reg;
`else
  assign trig_level = trig_s;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      trig_prev_reg <= 1'b0;
      trig_edge_reg <= 1'b0;
    end else begin
      trig_prev_reg <= trig_level;
      trig_edge_reg <= trig_level & ~trig_prev_reg;
    end
  end

  assign frame_cnt_inc = frame_cnt_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (trig_edge_reg) state_next = S_ARM;
      S_ARM:      if (frame_start) state_next = S_BLACK;
      S_BLACK:    if (frame_start) state_next = S_WHITE;
      S_WHITE:    if (frame_start) state_next = S_EVAL;
      S_EVAL:     state_next = S_COOLDOWN;
      S_COOLDOWN: begin
        if (COOLDOWN_FRAMES == 0) state_next = S_IDLE;
        else if (frame_start && frame_cnt_inc == FC_LAST) state_next = S_IDLE;
      end
      default:    state_next = S_IDLE;
    endcase
  end

  // Display requests follow the next state so their edges land on the frame_start cycle + 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      black_light_reg <= 1'b0;
      det_cnt_reg     <= '0;
      frame_cnt_reg   <= '0;
      blank_reg       <= 1'b0;
      show_reg        <= 1'b0;
      hit_reg         <= 1'b0;
      miss_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      hit_count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      blank_reg <= (state_next == S_BLACK) || (state_next == S_WHITE);
      show_reg  <= (state_next == S_WHITE);
      busy_reg  <= (state_next != S_IDLE);
      hit_reg   <= 1'b0;
      miss_reg  <= 1'b0;
      case (state_reg)
        S_ARM: begin
          black_light_reg <= 1'b0;
          det_cnt_reg     <= '0;
        end
        S_BLACK: begin
          if (valid && detect_s) black_light_reg <= 1'b1;
        end
        S_WHITE: begin
          if (valid && detect_s && det_cnt_reg != CNT_MAX) det_cnt_reg <= det_cnt_reg + 1'b1;
        end
        S_EVAL: begin
          frame_cnt_reg <= '0;
          if (!black_light_reg && det_cnt_reg >= MIN_DET) begin
            hit_reg <= 1'b1;
            if (hit_count_reg != 8'hFF) hit_count_reg <= hit_count_reg + 1'b1;
          end else begin
            miss_reg <= 1'b1;
          end
        end
        S_COOLDOWN: begin
          if (frame_start) frame_cnt_reg <= frame_cnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign blank_screen = blank_reg;
  assign show_target  = show_reg;
  assign hit          = hit_reg;
  assign miss         = miss_reg;
  assign busy         = busy_reg;
  assign hit_count    = hit_count_reg;

endmodule

// File: tb/tb_shot_detector.sv
// Directed bench for shot_detector: table of full shots plus hand-written retrigger, reset and debounce sequences.
module tb_shot_detector;

  localparam int LEAD      = 8;
  localparam int VIS       = 104;
  localparam int TRAIL     = 4;
  localparam int FRAME_LEN = 1 + LEAD + VIS + TRAIL;
  localparam int COOL      = 30;
  localparam int NVEC      = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       trigger = 1'b0;
  logic       detect = 1'b0;
  logic       frame_start = 1'b0;
  logic       valid = 1'b0;
  logic       blank_screen;
  logic       show_target;
  logic       hit;
  logic       miss;
  logic       busy;
  logic [7:0] hit_count;

  always #5 clk = ~clk;

  shot_detector #(
    .MIN_DETECT(16),
    .CNT_W(12),
    .COOLDOWN_FRAMES(COOL),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .detect(detect),
    .frame_start(frame_start),
    .valid(valid),
    .blank_screen(blank_screen),
    .show_target(show_target),
    .hit(hit),
    .miss(miss),
    .busy(busy),
    .hit_count(hit_count)
  );

  typedef struct {
    int         black_det;
    int         white_det;
    int         white_invis;
    bit         exp_hit;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  int   hit_pulses = 0;
  int   miss_pulses = 0;
  int   blank_cycles = 0;
  int   show_cycles = 0;
  int   overlap_err = 0;
  int   width_err = 0;
  logic hit_q = 1'b0;
  logic miss_q = 1'b0;

  always @(negedge clk) begin
    if (hit === 1'b1) hit_pulses <= hit_pulses + 1;
    if (miss === 1'b1) miss_pulses <= miss_pulses + 1;
    if (blank_screen === 1'b1) blank_cycles <= blank_cycles + 1;
    if (show_target === 1'b1) show_cycles <= show_cycles + 1;
    if (hit === 1'b1 && miss === 1'b1) overlap_err <= overlap_err + 1;
    if ((hit === 1'b1 && hit_q === 1'b1) || (miss === 1'b1 && miss_q === 1'b1)) width_err <= width_err + 1;
    hit_q  <= hit;
    miss_q <= miss;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic do_frame(input int vis_det, input int invis_det);
    frame_start = 1'b1;
    valid = 1'b0;
    detect = 1'b0;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < LEAD; i++) begin
      detect = (i < invis_det);
      tick();
    end
    for (int i = 0; i < VIS; i++) begin
      valid = 1'b1;
      detect = (i < vis_det);
      tick();
    end
    valid = 1'b0;
    detect = 1'b0;
    for (int i = 0; i < TRAIL; i++) tick();
  endtask

  task automatic pull_trigger;
    trigger = 1'b1;
    repeat (12) tick();
    trigger = 1'b0;
    tick();
  endtask

  task automatic start_shot(input string name);
    int n;
    pull_trigger();
    n = 0;
    while (busy !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check(name, busy, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_blank"}, blank_screen, 0);
    check({tag, "_show"}, show_target, 0);
    check({tag, "_hit"}, hit, 0);
    check({tag, "_miss"}, miss, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_count"}, hit_count, 0);
  endtask

  initial begin
    int h0, m0, b0, s0;

    vecs[0] = '{black_det: 0, white_det: 20,  white_invis: 0, exp_hit: 1'b1, exp_count: 8'd1};
    vecs[1] = '{black_det: 0, white_det: 5,   white_invis: 0, exp_hit: 1'b0, exp_count: 8'd1};
    vecs[2] = '{black_det: 1, white_det: 100, white_invis: 0, exp_hit: 1'b0, exp_count: 8'd1};
    vecs[3] = '{black_det: 0, white_det: 0,   white_invis: 4, exp_hit: 1'b0, exp_count: 8'd1};
    vecs[4] = '{black_det: 0, white_det: 16,  white_invis: 0, exp_hit: 1'b1, exp_count: 8'd2};
    vecs[5] = '{black_det: 0, white_det: 15,  white_invis: 0, exp_hit: 1'b0, exp_count: 8'd2};

    reset = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

`ifdef TRIGGER_DEBOUNCE_EN
    trigger = 1'b1;
    repeat (5) tick();
    trigger = 1'b0;
    repeat (30) tick();
    check("debounce_glitch_busy", busy, 0);
    $display("debounce glitch: busy=%0d", busy);
    start_shot("debounce_press_busy");
    $display("debounce press: busy=%0d", busy);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
`endif

    for (int v = 0; v < NVEC; v++) begin
      h0 = hit_pulses;
      m0 = miss_pulses;
      b0 = blank_cycles;
      s0 = show_cycles;
      start_shot($sformatf("v%0d_arm", v));
      do_frame(vecs[v].black_det, 0);
      do_frame(vecs[v].white_det, vecs[v].white_invis);
      do_frame(0, 0);
      check($sformatf("v%0d_hit", v), hit_pulses - h0, vecs[v].exp_hit ? 1 : 0);
      check($sformatf("v%0d_miss", v), miss_pulses - m0, vecs[v].exp_hit ? 0 : 1);
      check($sformatf("v%0d_count", v), hit_count, vecs[v].exp_count);
      check($sformatf("v%0d_blank_cycles", v), blank_cycles - b0, 2 * FRAME_LEN);
      check($sformatf("v%0d_show_cycles", v), show_cycles - s0, FRAME_LEN);
      for (int f = 0; f < COOL - 1; f++) do_frame(0, 0);
      check($sformatf("v%0d_busy_cool29", v), busy, 1);
      do_frame(0, 0);
      check($sformatf("v%0d_busy_cool30", v), busy, 0);
      $display("shot %0d: hits=%0d misses=%0d hit_count=%0d", v, hit_pulses - h0, miss_pulses - m0, hit_count);
    end

    // Extra trigger pulls in BLACK and COOLDOWN must not restart or queue a shot.
    h0 = hit_pulses;
    m0 = miss_pulses;
    start_shot("retrig_arm");
    do_frame(0, 0);
    pull_trigger();
    check("retrig_black_show", show_target, 0);
    do_frame(20, 0);
    do_frame(0, 0);
    for (int f = 0; f < 10; f++) do_frame(0, 0);
    pull_trigger();
    for (int f = 0; f < COOL - 11; f++) do_frame(0, 0);
    check("retrig_busy_cool29", busy, 1);
    do_frame(0, 0);
    check("retrig_busy_cool30", busy, 0);
    repeat (20) tick();
    check("retrig_no_queue", busy, 0);
    check("retrig_hits", hit_pulses - h0, 1);
    check("retrig_misses", miss_pulses - m0, 0);
    check("retrig_count", hit_count, 3);
    $display("retrigger shot: hits=%0d misses=%0d hit_count=%0d", hit_pulses - h0, miss_pulses - m0, hit_count);

    // New trigger after IDLE is accepted; reset mid-WHITE aborts it.
    start_shot("rearm_busy");
    do_frame(0, 0);
    do_frame(20, 0);
    check("midwhite_show", show_target, 1);
    h0 = hit_pulses;
    m0 = miss_pulses;
    reset = 1'b0;
    tick();
    check_all_zero("midwhite_reset");
    reset = 1'b1;
    for (int f = 0; f < 3; f++) do_frame(0, 0);
    check("post_reset_hits", hit_pulses - h0, 0);
    check("post_reset_misses", miss_pulses - m0, 0);
    check("post_reset_busy", busy, 0);
    $display("reset mid-white: hits=%0d misses=%0d busy=%0d", hit_pulses - h0, miss_pulses - m0, busy);

    check("pulse_overlap", overlap_err, 0);
    check("pulse_width", width_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
